// File: rtl/vvp_acc_if.sv
// Stream interface for vvp_acc: beat input side (weights/data/mode) and
// per-packet result side (saturated sum plus sticky overflow).
interface vvp_acc_if #(
  parameter int N  = 64,
  parameter int AW = 32
);
  logic                 in_valid;
  logic                 in_last;
  logic [1:0]           mode;
  logic [N-1:0]         W;
  logic [2*N-1:0]       D;
  logic                 out_valid;
  logic signed [AW-1:0] out_sum;
  logic                 out_ovf;

  modport master (
    output in_valid, in_last, mode, W, D,
    input  out_valid, out_sum, out_ovf
  );

  modport slave (
    input  in_valid, in_last, mode, W, D,
    output out_valid, out_sum, out_ovf
  );
endinterface

// File: rtl/vvp_acc.sv
// Pipelined multi-beat vector-vector product with saturating per-packet
// accumulation; one beat per cycle, result pulse on the packet's last beat.
module vvp_acc #(
  parameter int N  = 64,
  parameter int AW = 32,
  parameter int PD = 1
) (
  input logic      clk,
  input logic      rst,
  vvp_acc_if.slave bus
);
  localparam int PW = $clog2(N) + 3;
  localparam int NP = 1 << $clog2(N);

  function automatic logic signed [2:0] elem_prod(input logic [1:0] m, input logic w,
                                                  input logic [1:0] d);
    logic signed [2:0] dx;
    logic signed [2:0] r;
    dx = {d[1], d};
    case (m)
      2'b00:   r = w ? -dx : dx;
      2'b01:   r = w ? dx : 3'sb000;
      2'b10:   r = w ? -dx : 3'sb000;
      2'b11:   r = 3'sb000;
      default: r = 3'sb000;
    endcase
    return r;
  endfunction

  // Balanced tree over a zero-padded power-of-two leaf set; padding adds zeros
  // so the result matches the uneven nl/nr split exactly.
  function automatic logic signed [PW-1:0] beat_product(input logic [1:0] m,
                                                        input logic [N-1:0] w,
                                                        input logic [2*N-1:0] d);
    logic [NP-1:0]          wp;
    logic [2*NP-1:0]        dp;
    logic signed [PW-1:0]   node [2*NP-1];
    wp = NP'(w);
    dp = (2*NP)'(d);
    for (int i = 0; i < NP; i++) begin
      if (i < N) begin
        node[NP-1+i] = PW'(elem_prod(m, wp[i], dp[2*i+:2]));
      end else begin
        node[NP-1+i] = {PW{1'b0}};
      end
    end
    for (int k = NP - 2; k >= 0; k--) begin
      node[k] = node[2*k+1] + node[2*k+2];
    end
    return node[0];
  endfunction

  logic                 in_v_r;
  logic                 in_l_r;
  logic [1:0]           mode_r;
  logic [N-1:0]         w_r;
  logic [2*N-1:0]       d_r;
  logic signed [PW-1:0] tap_p_s;
  logic                 acc_v_s;
  logic                 acc_l_s;
  logic signed [PW-1:0] acc_p_s;
  logic signed [AW-1:0] acc_r;
  logic                 ovf_r;
  logic                 first_r;
  logic signed [AW:0]   base_s;
  logic signed [AW:0]   sum_s;
  logic signed [AW-1:0] sat_s;
  logic                 clip_s;
  logic                 out_valid_r;
  logic signed [AW-1:0] out_sum_r;
  logic                 out_ovf_r;

  // Input capture register
  always_ff @(posedge clk) begin
    if (rst) begin
      in_v_r <= 1'b0;
      in_l_r <= 1'b0;
      mode_r <= 2'b00;
      w_r    <= {N{1'b0}};
      d_r    <= {(2*N){1'b0}};
    end else begin
      in_v_r <= bus.in_valid;
      in_l_r <= bus.in_last;
      mode_r <= bus.mode;
      w_r    <= bus.W;
      d_r    <= bus.D;
    end
  end

  // Beat product from the captured beat
  always_comb begin
    tap_p_s = beat_product(mode_r, w_r, d_r);
  end

  generate
    if (PD == 0) begin : g_nopipe
      assign acc_v_s = in_v_r;
      assign acc_l_s = in_l_r;
      assign acc_p_s = tap_p_s;
    end else begin : g_pipe
      logic [PD-1:0]        v_r;
      logic [PD-1:0]        l_r;
      logic signed [PW-1:0] p_r [PD];

      // Product delay line with valid/last sideband
      always_ff @(posedge clk) begin
        if (rst) begin
          v_r <= {PD{1'b0}};
          l_r <= {PD{1'b0}};
          for (int j = 0; j < PD; j++) p_r[j] <= {PW{1'b0}};
        end else begin
          v_r[0] <= in_v_r;
          l_r[0] <= in_l_r;
          p_r[0] <= tap_p_s;
          for (int j = 1; j < PD; j++) begin
            v_r[j] <= v_r[j-1];
            l_r[j] <= l_r[j-1];
            p_r[j] <= p_r[j-1];
          end
        end
      end

      assign acc_v_s = v_r[PD-1];
      assign acc_l_s = l_r[PD-1];
      assign acc_p_s = p_r[PD-1];
    end
  endgenerate

  // One guard bit above AW: overflow iff the top two bits disagree
  always_comb begin
    base_s = first_r ? {(AW+1){1'b0}} : (AW+1)'(acc_r);
    sum_s  = base_s + (AW+1)'(acc_p_s);
    if (sum_s[AW] != sum_s[AW-1]) begin
      clip_s = 1'b1;
      sat_s  = sum_s[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      clip_s = 1'b0;
      sat_s  = sum_s[AW-1:0];
    end
  end

  // Packet accumulator and registered result
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_r       <= {AW{1'b0}};
      ovf_r       <= 1'b0;
      first_r     <= 1'b1;
      out_valid_r <= 1'b0;
      out_sum_r   <= {AW{1'b0}};
      out_ovf_r   <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (acc_v_s) begin
        if (acc_l_s) begin
          out_valid_r <= 1'b1;
          out_sum_r   <= sat_s;
          out_ovf_r   <= ovf_r | clip_s;
          first_r     <= 1'b1;
          ovf_r       <= 1'b0;
        end else begin
          acc_r   <= sat_s;
          ovf_r   <= ovf_r | clip_s;
          first_r <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.out_ovf   = out_ovf_r;
endmodule
